// File: rtl/main.sv
// 2x2 weight-stationary systolic array computing C = A x W on hardcoded operands.
// Activations flow right and partial sums flow down; results are captured from the bottom row.
module main #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  c00,
    output logic [ACC_W-1:0]  c01,
    output logic [ACC_W-1:0]  c10,
    output logic [ACC_W-1:0]  c11
);

    typedef enum logic [1:0] {StIdle, StLoadW, StCompute, StDone} state_e;

    localparam logic [DATA_W-1:0] A00 = DATA_W'(5);
    localparam logic [DATA_W-1:0] A01 = DATA_W'(6);
    localparam logic [DATA_W-1:0] A10 = DATA_W'(7);
    localparam logic [DATA_W-1:0] A11 = DATA_W'(8);
    localparam logic [DATA_W-1:0] W00 = DATA_W'(1);
    localparam logic [DATA_W-1:0] W01 = DATA_W'(2);
    localparam logic [DATA_W-1:0] W10 = DATA_W'(3);
    localparam logic [DATA_W-1:0] W11 = DATA_W'(4);

    state_e              state;
    logic [2:0]          cnt;
    logic [DATA_W-1:0]   w_q   [2][2];
    logic [DATA_W-1:0]   a_q   [2];
    logic [ACC_W-1:0]    ps_q  [2][2];
    logic [DATA_W-1:0]   feed  [2];
    logic [DATA_W-1:0]   a_in  [2][2];
    logic [ACC_W-1:0]    ps_in [2][2];
    logic [2*DATA_W-1:0] prod  [2][2];

    // Row 1 is fed one cycle after row 0 so its operands meet the psum arriving from above.
    always_comb begin
        feed[0] = '0;
        feed[1] = '0;
        if (state == StCompute) begin
            if (cnt == 3'd0) feed[0] = A00;
            if (cnt == 3'd1) feed[0] = A10;
            if (cnt == 3'd1) feed[1] = A01;
            if (cnt == 3'd2) feed[1] = A11;
        end
    end

    always_comb begin
        a_in[0][0]  = feed[0];
        a_in[0][1]  = a_q[0];
        a_in[1][0]  = feed[1];
        a_in[1][1]  = a_q[1];
        ps_in[0][0] = '0;
        ps_in[0][1] = '0;
        ps_in[1][0] = ps_q[0][0];
        ps_in[1][1] = ps_q[0][1];
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                prod[i][j] = (2*DATA_W)'(a_in[i][j]) * (2*DATA_W)'(w_q[i][j]);
            end
        end
    end

    // PE pipeline registers; only column 0 forwards its activation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                a_q[i] <= '0;
                for (int j = 0; j < 2; j++) begin
                    ps_q[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                a_q[i] <= a_in[i][0];
                for (int j = 0; j < 2; j++) begin
                    ps_q[i][j] <= ps_in[i][j] + ACC_W'(prod[i][j]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            c00   <= '0;
            c01   <= '0;
            c10   <= '0;
            c11   <= '0;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    w_q[i][j] <= '0;
                end
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state <= StLoadW;
                        busy  <= 1'b1;
                    end
                end
                StLoadW: begin
                    w_q[0][0] <= W00;
                    w_q[0][1] <= W01;
                    w_q[1][0] <= W10;
                    w_q[1][1] <= W11;
                    cnt       <= '0;
                    state     <= StCompute;
                end
                StCompute: begin
                    cnt <= cnt + 3'd1;
                    // Column 1 results trail column 0 by one cycle of skew.
                    if (cnt == 3'd2) c00 <= ps_q[1][0];
                    if (cnt == 3'd3) begin
                        c10 <= ps_q[1][0];
                        c01 <= ps_q[1][1];
                    end
                    if (cnt == 3'd4) c11 <= ps_q[1][1];
                    if (cnt == 3'd5) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                StDone: begin
                    if (start) begin
                        state <= StLoadW;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_main.sv
// Randomized bench for main: a transaction-level model tracks run progress and the
// expected product matrix, and every cycle is compared against it.
module tb_main;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] c00, c01, c10, c11;

    main #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .c00   (c00),
        .c01   (c01),
        .c10   (c10),
        .c11   (c11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Model state: edges since the accepting edge, and whether a result exists.
    bit running;
    bit in_done;
    bit have_res;
    int t;
    int cref [2][2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic compute_ref();
        int a [2][2];
        int w [2][2];
        a = '{'{5, 6}, '{7, 8}};
        w = '{'{1, 2}, '{3, 4}};
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 2; j++) begin
                cref[r][j] = 0;
                for (int k = 0; k < 2; k++) cref[r][j] += a[r][k] * w[k][j];
                cref[r][j] = cref[r][j] % (1 << ACC_W);
            end
        end
    endtask

    task automatic model_reset();
        running  = 0;
        in_done  = 0;
        have_res = 0;
        t        = 0;
    endtask

    task automatic model_edge(input logic st);
        if (running) begin
            t++;
            if (t == 7) begin
                running  = 0;
                in_done  = 1;
                have_res = 1;
            end
        end else if (st) begin
            running = 1;
            in_done = 0;
            t       = 0;
        end
    endtask

    task automatic check_all();
        check_val("busy", 32'(busy), 32'(running));
        check_val("done", 32'(done), 32'(in_done));
        check_val("excl", 32'(busy & done), 32'd0);
        // Results are stable except while the very first run after reset fills them.
        if (!(running && !have_res)) begin
            check_val("c00", 32'(c00), have_res ? 32'(cref[0][0]) : 32'd0);
            check_val("c01", 32'(c01), have_res ? 32'(cref[0][1]) : 32'd0);
            check_val("c10", 32'(c10), have_res ? 32'(cref[1][0]) : 32'd0);
            check_val("c11", 32'(c11), have_res ? 32'(cref[1][1]) : 32'd0);
        end
    endtask

    // Starts and ends at a falling edge.
    task automatic cycle(input logic st);
        start = st;
        @(posedge clk);
        model_edge(st);
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        start = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        compute_ref();
        model_reset();
        reset = 1'b1;
        start = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle with no start.
        for (int i = 0; i < 20; i++) cycle(1'b0);

        // Single pulse, then hold DONE for a while.
        cycle(1'b1);
        for (int i = 0; i < 18; i++) cycle(1'b0);

        // Start held high: back-to-back runs.
        for (int i = 0; i < 24; i++) cycle(1'b1);
        cycle(1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0);

        // Re-pulse during COMPUTE must be ignored.
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0);

        // Reset in the middle of COMPUTE, then a clean run.
        cycle(1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0);
        cycle(1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0);

        // Randomized segments with varying start density and occasional resets.
        for (int i = 0; i < 600; i++) begin
            int pct;
            pct = (i / 150 == 0) ? 10 : (i / 150 == 1) ? 50 : (i / 150 == 2) ? 90 : 30;
            if ($urandom_range(0, 99) < 2) do_reset();
            else cycle(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
